// File: rtl/mac_pkg.sv
// Shared quantizer types and helpers for the mac result path.
// Round-shift and int8 saturation are reused by later quantizers.
package mac_pkg;

    localparam int ACC_W    = 20;
    localparam int PSUM_W   = 32;
    localparam int OUT_W    = 8;
    localparam int LANES    = 16;
    localparam int CNT_W    = 8;
    localparam int BIAS_W   = 16;
    localparam int SHIFT_W  = 5;
    localparam int WORD_W   = LANES * OUT_W;
    localparam int LANE_W   = $clog2(LANES);
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Two guard bits so bias add and rounding offset never wrap.
    typedef logic signed [PSUM_W+1:0] wide_t;
    typedef logic signed [OUT_W-1:0]  q_t;

    function automatic wide_t round_shift(
        input wide_t               v,
        input logic [SHIFT_W-1:0]  sh
    );
        wide_t rnd;
        rnd = '0;
        if (sh != '0) begin
            rnd = wide_t'(1) << (sh - 1'b1);
        end
        return (v + rnd) >>> sh;
    endfunction

    function automatic q_t sat_int8(input wide_t r);
        q_t res;
        if (r > wide_t'(INT8_MAX)) begin
            res = q_t'(INT8_MAX);
        end else if (r < wide_t'(INT8_MIN)) begin
            res = q_t'(INT8_MIN);
        end else begin
            res = r[OUT_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_acc_writer_if.sv
// Packed output word stream towards the output buffer.
// Master drives data/valid, slave returns ready.
interface mac_acc_writer_if;
    import mac_pkg::*;

    logic [WORD_W-1:0] out_data;
    logic              out_vld;
    logic              out_rdy;

    modport master (
        output out_data,
        output out_vld,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_vld,
        output out_rdy
    );

endinterface

// File: rtl/mac_out_fifo.sv
// Two-entry valid/ready word FIFO; head is shown on data_o.
// A push into a full FIFO with no same-cycle pop is dropped and flagged.
module mac_out_fifo
    import mac_pkg::*;
#(
    parameter int W = WORD_W
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    output logic [W-1:0] data_o,
    output logic         vld_o,
    input  logic         rdy_i,
    output logic         full_o,
    output logic         empty_o,
    output logic         drop_o
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_q, wr_d;
    logic              rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pop;
    logic              accept;

    assign data_o  = mem_q[rd_q];
    assign vld_o   = (cnt_q != 2'd0);
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign pop     = vld_o && rdy_i && !clr_i;
    assign accept  = push_i && !clr_i && (!full_o || pop);
    assign drop_o  = push_i && !clr_i && full_o && !pop;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            mem_d = '0;
            wr_d  = 1'b0;
            rd_d  = 1'b0;
            cnt_d = 2'd0;
        end else begin
            if (pop) begin
                rd_d = ~rd_q;
            end
            // When full, wr_q equals rd_q: the slot being popped is reused.
            if (accept) begin
                mem_d[wr_q] = data_i;
                wr_d        = ~wr_q;
            end
            cnt_d = cnt_q + {1'b0, accept} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            mem_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mac_acc_writer.sv
// Tile accumulate, bias/round/relu/saturate, pack 16 int8 lanes per word.
// Input side never stalls; a full output queue drops words and flags it.
module mac_acc_writer
    import mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     start,
    input  logic [CNT_W-1:0]         cfg_num_tiles,
    input  logic signed [BIAS_W-1:0] cfg_bias,
    input  logic [SHIFT_W-1:0]       cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     vld_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    mac_acc_writer_if.master         out,
    output logic                     busy,
    output logic                     err_ovf
);

    logic [CNT_W-1:0]          num_tiles_q, num_tiles_d;
    logic signed [BIAS_W-1:0]  bias_q, bias_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic                      relu_q, relu_d;

    logic signed [PSUM_W-1:0]  psum_q, psum_d;
    logic [CNT_W-1:0]          tile_cnt_q, tile_cnt_d;
    logic                      pix_vld_q, pix_vld_d;
    q_t                        qval_q, qval_d;
    logic                      q_vld_q, q_vld_d;
    logic [LANE_W-1:0]         lane_cnt_q, lane_cnt_d;
    logic [LANES-1:0][OUT_W-1:0] pack_q, pack_d;
    logic                      err_q, err_d;

    logic                      push;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic                      fifo_drop;
    logic signed [PSUM_W-1:0]  acc_ext;
    wide_t                     v_w;
    wide_t                     r_w;

    assign acc_ext = {{(PSUM_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};

    always_comb begin
        num_tiles_d = num_tiles_q;
        bias_d      = bias_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        psum_d      = psum_q;
        tile_cnt_d  = tile_cnt_q;
        pix_vld_d   = 1'b0;
        qval_d      = qval_q;
        q_vld_d     = 1'b0;
        lane_cnt_d  = lane_cnt_q;
        pack_d      = pack_q;
        err_d       = err_q | fifo_drop;
        push        = 1'b0;
        v_w         = wide_t'(psum_q) + wide_t'(bias_q);
        r_w         = round_shift(v_w, shift_q);
        if (relu_q && r_w[PSUM_W+1]) begin
            r_w = '0;
        end

        if (start) begin
            num_tiles_d = (cfg_num_tiles == '0) ? CNT_W'(1) : cfg_num_tiles;
            bias_d      = cfg_bias;
            shift_d     = cfg_shift;
            relu_d      = cfg_relu;
            psum_d      = '0;
            tile_cnt_d  = '0;
            lane_cnt_d  = '0;
            pack_d      = '0;
            err_d       = 1'b0;
        end else begin
            if (vld_i) begin
                psum_d = ((tile_cnt_q == '0) ? '0 : psum_q) + acc_ext;
                if (tile_cnt_q == num_tiles_q - CNT_W'(1)) begin
                    tile_cnt_d = '0;
                    pix_vld_d  = 1'b1;
                end else begin
                    tile_cnt_d = tile_cnt_q + CNT_W'(1);
                end
            end
            if (pix_vld_q) begin
                qval_d  = sat_int8(r_w);
                q_vld_d = 1'b1;
            end
            if (q_vld_q) begin
                pack_d[lane_cnt_q] = qval_q;
                lane_cnt_d         = lane_cnt_q + LANE_W'(1);
                push               = (lane_cnt_q == LANE_W'(LANES-1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            num_tiles_q <= CNT_W'(1);
            bias_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            psum_q      <= '0;
            tile_cnt_q  <= '0;
            pix_vld_q   <= 1'b0;
            qval_q      <= '0;
            q_vld_q     <= 1'b0;
            lane_cnt_q  <= '0;
            pack_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            num_tiles_q <= num_tiles_d;
            bias_q      <= bias_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            psum_q      <= psum_d;
            tile_cnt_q  <= tile_cnt_d;
            pix_vld_q   <= pix_vld_d;
            qval_q      <= qval_d;
            q_vld_q     <= q_vld_d;
            lane_cnt_q  <= lane_cnt_d;
            pack_q      <= pack_d;
            err_q       <= err_d;
        end
    end

    mac_out_fifo #(
        .W (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (start),
        .push_i  (push),
        .data_i  (pack_d),
        .data_o  (out.out_data),
        .vld_o   (out.out_vld),
        .rdy_i   (out.out_rdy),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .drop_o  (fifo_drop)
    );

    assign err_ovf = err_q;
    assign busy    = (tile_cnt_q != '0) || (lane_cnt_q != '0) ||
                     pix_vld_q || q_vld_q || !fifo_empty;

endmodule

// File: tb/tb_mac_acc_writer.sv
// Directed bench for mac_acc_writer with hand-computed words.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_mac_acc_writer;
    import mac_pkg::*;

    logic                     clk;
    logic                     rstn;
    logic                     start;
    logic [CNT_W-1:0]         cfg_num_tiles;
    logic signed [BIAS_W-1:0] cfg_bias;
    logic [SHIFT_W-1:0]       cfg_shift;
    logic                     cfg_relu;
    logic                     vld_i;
    logic signed [ACC_W-1:0]  acc_i;
    logic                     busy;
    logic                     err_ovf;

    int n_chk;
    int n_pass;

    mac_acc_writer_if u_if ();

    mac_acc_writer dut (
        .clk           (clk),
        .rstn          (rstn),
        .start         (start),
        .cfg_num_tiles (cfg_num_tiles),
        .cfg_bias      (cfg_bias),
        .cfg_shift     (cfg_shift),
        .cfg_relu      (cfg_relu),
        .vld_i         (vld_i),
        .acc_i         (acc_i),
        .out           (u_if),
        .busy          (busy),
        .err_ovf       (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input int nt, input int bias, input int sh,
                       input logic relu);
        cfg_num_tiles = nt[CNT_W-1:0];
        cfg_bias      = bias[BIAS_W-1:0];
        cfg_shift     = sh[SHIFT_W-1:0];
        cfg_relu      = relu;
        start         = 1'b1;
        tick(1);
        start         = 1'b0;
    endtask

    task automatic beat(input int v);
        vld_i = 1'b1;
        acc_i = v[ACC_W-1:0];
        tick(1);
        vld_i = 1'b0;
    endtask

    task automatic stream(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            beat(base + k);
        end
    endtask

    task automatic pop_word(input string tag, input logic [127:0] exp);
        int i;
        i = 0;
        while (!u_if.out_vld && i < 20) begin
            tick(1);
            i++;
        end
        chk({tag, "_vld"}, u_if.out_vld, 1'b1);
        chk({tag, "_data"}, u_if.out_data, exp);
        u_if.out_rdy = 1'b1;
        tick(1);
        u_if.out_rdy = 1'b0;
    endtask

    localparam logic [127:0] W0 = 128'h0F0E0D0C0B0A09080706050403020100;
    localparam logic [127:0] W1 = 128'h1F1E1D1C1B1A19181716151413121110;
    localparam logic [127:0] W18 = {16{8'h18}};
    localparam logic [127:0] W01 = {16{8'h01}};

    initial begin
        n_chk = 0;
        n_pass = 0;
        rstn = 1'b0;
        start = 1'b0;
        cfg_num_tiles = '0;
        cfg_bias = '0;
        cfg_shift = '0;
        cfg_relu = 1'b0;
        vld_i = 1'b0;
        acc_i = '0;
        u_if.out_rdy = 1'b0;
        tick(3);
        chk("rst_vld", u_if.out_vld, 1'b0);
        chk("rst_data", u_if.out_data, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err_ovf, 1'b0);
        rstn = 1'b1;
        tick(1);

        cfg(1, 0, 0, 1'b0);
        stream(0, 16);
        chk("lat_t1", u_if.out_vld, 1'b0);
        tick(1);
        chk("lat_t2", u_if.out_vld, 1'b0);
        tick(1);
        chk("lat_t3", u_if.out_vld, 1'b1);
        chk("t1_busy", busy, 1'b1);
        pop_word("t1", W0);
        chk("t1_idle", busy, 1'b0);

        cfg(3, 10, 2, 1'b0);
        beat(100);
        chk("t2_busy", busy, 1'b1);
        beat(-20);
        beat(5);
        for (int p = 1; p < 16; p++) begin
            beat(100);
            beat(-20);
            beat(5);
        end
        pop_word("t2", W18);

        cfg(1, 0, 0, 1'b0);
        beat(500000);
        beat(-500000);
        stream(0, 1);
        for (int p = 0; p < 13; p++) beat(0);
        pop_word("t3_sat", 128'h807F);
        cfg(1, 0, 0, 1'b1);
        beat(500000);
        beat(-500000);
        for (int p = 0; p < 14; p++) beat(0);
        pop_word("t3_relu", 128'h7F);

        cfg(0, 0, 0, 1'b0);
        for (int p = 0; p < 16; p++) beat(1);
        pop_word("nt0", W01);

        cfg(1, 0, 0, 1'b0);
        stream(0, 48);
        tick(4);
        chk("ovf_err", err_ovf, 1'b1);
        chk("ovf_hold", u_if.out_data, W0);
        pop_word("ovf_w0", W0);
        pop_word("ovf_w1", W1);
        tick(4);
        chk("ovf_empty", u_if.out_vld, 1'b0);
        cfg(1, 0, 0, 1'b0);
        chk("ovf_clr", err_ovf, 1'b0);

        stream(0, 7);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(3);
        chk("rst7_vld", u_if.out_vld, 1'b0);
        chk("rst7_busy", busy, 1'b0);
        stream(16, 15);
        tick(4);
        chk("rst7_early", u_if.out_vld, 1'b0);
        beat(31);
        pop_word("rst7", W1);
        tick(4);
        chk("rst7_one", u_if.out_vld, 1'b0);

        cfg(1, 0, 0, 1'b0);
        stream(0, 7);
        cfg(1, 0, 0, 1'b0);
        tick(3);
        chk("st7_busy", busy, 1'b0);
        stream(16, 15);
        tick(4);
        chk("st7_early", u_if.out_vld, 1'b0);
        beat(31);
        pop_word("st7", W1);
        tick(4);
        chk("st7_one", u_if.out_vld, 1'b0);

        cfg(1, 0, 1, 1'b0);
        beat(-3);
        beat(3);
        for (int p = 0; p < 14; p++) beat(0);
        pop_word("rnd1", 128'h02FF);
        chk("rs_m3", round_shift(-34'sd3, 5'd1), -34'sd1);
        chk("rs_p3", round_shift(34'sd3, 5'd1), 34'sd2);
        chk("rs_max", round_shift(34'sh7FFFFFFF, 5'd31), 34'sd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
